// File: rtl/keypress_sequencer_if.sv
// Cipher request/acknowledge bus between keypress_sequencer and the Enigma core.
// The sequencer drives the request side (master); the cipher core answers (slave).
interface keypress_sequencer_if;
    logic       enc_req;
    logic [4:0] enc_letter;
    logic       enc_ack;
    logic [4:0] enc_result;

    modport master (
        output enc_req,
        output enc_letter,
        input  enc_ack,
        input  enc_result
    );

    modport slave (
        input  enc_req,
        input  enc_letter,
        output enc_ack,
        output enc_result
    );
endinterface

// File: rtl/keypress_sequencer.sv
// keypress_sequencer: turns raw PS/2 set-2 scan bytes into letter presses,
// issues one cipher request per press, and keeps a short history of
// ciphertext letters for the seven-segment display.
//
// Optional feature macro: BACKSPACE_EN
//   defined   - make code 66 deletes the newest history entry while idle,
//               and pulses overrun if it arrives while a request is pending.
//   undefined - 66 is treated like any other non-letter code (ignored).
module keypress_sequencer #(
    parameter int DIGITS  = 4,     // history depth, 1..8
    parameter int TIMEOUT = 1024   // ack wait budget in cycles, >= 2
) (
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic                  scan_valid,
    input  logic [7:0]            scan_code,
    keypress_sequencer_if.master  enc,
    output logic [5*DIGITS-1:0]   disp_letters,
    output logic [3:0]            disp_count,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [4:0] BLANK     = 5'h1F;
    localparam int         CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       COUNT_MAX = 4'(DIGITS);

    typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXTBRK} dstate_t;
    typedef enum logic       {S_IDLE, S_WAIT} istate_t;

    dstate_t          r_dstate;
    istate_t          r_istate;
    logic             r_held_valid;
    logic [7:0]       r_held_code;
    logic             r_enc_req;
    logic [4:0]       r_enc_letter;
    logic             r_busy;
    logic             r_overrun;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_hist [DIGITS];
    logic [3:0]       r_disp_count;

    logic             w_is_letter;
    logic [4:0]       w_letter_idx;
    logic             w_make;
    logic             w_repeat;
    logic             w_press;
    logic             w_press_drop;
    logic             w_ack_done;
    logic             w_bksp_hit;
    logic             w_bksp_del;
    logic             w_bksp_ovr;

    // Map a set-2 make code to its letter index (A=0 .. Z=25).
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_is_letter  = 1'b1;
        w_letter_idx = 5'd0;
        case (scan_code)
            8'h1C: w_letter_idx = 5'd0;
            8'h32: w_letter_idx = 5'd1;
            8'h21: w_letter_idx = 5'd2;
            8'h23: w_letter_idx = 5'd3;
            8'h24: w_letter_idx = 5'd4;
            8'h2B: w_letter_idx = 5'd5;
            8'h34: w_letter_idx = 5'd6;
            8'h33: w_letter_idx = 5'd7;
            8'h43: w_letter_idx = 5'd8;
            8'h3B: w_letter_idx = 5'd9;
            8'h42: w_letter_idx = 5'd10;
            8'h4B: w_letter_idx = 5'd11;
            8'h3A: w_letter_idx = 5'd12;
            8'h31: w_letter_idx = 5'd13;
            8'h44: w_letter_idx = 5'd14;
            8'h4D: w_letter_idx = 5'd15;
            8'h15: w_letter_idx = 5'd16;
            8'h2D: w_letter_idx = 5'd17;
            8'h1B: w_letter_idx = 5'd18;
            8'h2C: w_letter_idx = 5'd19;
            8'h3C: w_letter_idx = 5'd20;
            8'h2A: w_letter_idx = 5'd21;
            8'h1D: w_letter_idx = 5'd22;
            8'h22: w_letter_idx = 5'd23;
            8'h35: w_letter_idx = 5'd24;
            8'h1A: w_letter_idx = 5'd25;
            default: w_is_letter = 1'b0;
        endcase
    end

    // A letter make in D_IDLE is a press unless it repeats the held key.
    assign w_make       = scan_valid && (r_dstate == D_IDLE) && w_is_letter;
    assign w_repeat     = w_make && r_held_valid && (r_held_code == scan_code);
    assign w_press      = w_make && !w_repeat;
    assign w_press_drop = w_press && r_busy;
    assign w_ack_done   = (r_istate == S_WAIT) && enc.enc_ack;

`ifdef BACKSPACE_EN
    assign w_bksp_hit = scan_valid && (r_dstate == D_IDLE) && (scan_code == 8'h66);
`else
    assign w_bksp_hit = 1'b0;
`endif
    assign w_bksp_del = w_bksp_hit && !r_busy;
    assign w_bksp_ovr = w_bksp_hit && r_busy;

    // Decode FSM: track F0/E0 prefixes and the currently held letter key.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_dstate     <= D_IDLE;
            r_held_valid <= 1'b0;
            r_held_code  <= 8'h00;
        end else if (scan_valid) begin
            case (r_dstate)
                D_IDLE: begin
                    if (scan_code == CODE_BRK) begin
                        r_dstate <= D_BRK;
                    end else if (scan_code == CODE_EXT) begin
                        r_dstate <= D_EXT;
                    end else if (w_press) begin
                        // The key is held even if the press itself is dropped.
                        r_held_valid <= 1'b1;
                        r_held_code  <= scan_code;
                    end
                end
                D_BRK: begin
                    r_dstate <= D_IDLE;
                    if (r_held_valid && (scan_code == r_held_code)) begin
                        r_held_valid <= 1'b0;
                    end
                end
                D_EXT: begin
                    r_dstate <= (scan_code == CODE_BRK) ? D_EXTBRK : D_IDLE;
                end
                default: begin
                    r_dstate <= D_IDLE;
                end
            endcase
        end
    end

    // Issue FSM: one outstanding cipher request, abandoned after TIMEOUT cycles.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_istate      <= S_IDLE;
            r_enc_req     <= 1'b0;
            r_enc_letter  <= 5'd0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_overrun     <= w_press_drop || w_bksp_ovr;
            r_timeout_err <= 1'b0;
            case (r_istate)
                S_IDLE: begin
                    if (w_press) begin
                        r_enc_letter <= w_letter_idx;
                        r_enc_req    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_istate     <= S_WAIT;
                    end
                end
                default: begin
                    // Ack takes priority over an expiring counter.
                    if (enc.enc_ack) begin
                        r_enc_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_istate  <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_enc_req     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_istate      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // History: push ciphertext on ack, optionally pop newest on backspace.
    // NOTE: the history array is reset because blank (1F) slots are visible on the display.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < DIGITS; k++) begin
                r_hist[k] <= BLANK;
            end
            r_disp_count <= 4'd0;
        end else if (w_ack_done) begin
            for (int k = DIGITS - 1; k > 0; k--) begin
                r_hist[k] <= r_hist[k-1];
            end
            r_hist[0] <= enc.enc_result;
            if (r_disp_count != COUNT_MAX) begin
                r_disp_count <= r_disp_count + 4'd1;
            end
        end else if (w_bksp_del && (r_disp_count != 4'd0)) begin
            for (int k = 0; k < DIGITS - 1; k++) begin
                r_hist[k] <= r_hist[k+1];
            end
            r_hist[DIGITS-1] <= BLANK;
            r_disp_count     <= r_disp_count - 4'd1;
        end
    end

    // Flatten the history into the display bus, slot 0 in the low bits.
    always_comb begin
        disp_letters = '0;
        for (int k = 0; k < DIGITS; k++) begin
            disp_letters[5*k +: 5] = r_hist[k];
        end
    end

    assign enc.enc_req    = r_enc_req;
    assign enc.enc_letter = r_enc_letter;
    assign disp_count     = r_disp_count;
    assign busy           = r_busy;
    assign overrun        = r_overrun;
    assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_keypress_sequencer.sv
// Directed bench for keypress_sequencer (DIGITS=4, TIMEOUT=1024).
// Covers BACKSPACE_EN in either build.
module tb_keypress_sequencer;

    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 1024;

    logic                 clock;
    logic                 reset_L;
    logic                 scan_valid;
    logic [7:0]           scan_code;
    logic [5*DIGITS-1:0]  disp_letters;
    logic [3:0]           disp_count;
    logic                 busy;
    logic                 overrun;
    logic                 timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    keypress_sequencer_if u_if ();

    keypress_sequencer #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .enc          (u_if),
        .disp_letters (disp_letters),
        .disp_count   (disp_count),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count rising edges of enc_req, sampled mid-cycle.
    always @(negedge clock) begin
        if (u_if.enc_req === 1'b1 && req_prev === 1'b0) req_rises++;
        req_prev = u_if.enc_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [19:0] pack(input logic [4:0] s3, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [4:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        scan_valid = 1'b1;
        scan_code  = code;
        tick();
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic ack(input logic [4:0] res);
        u_if.enc_ack    = 1'b1;
        u_if.enc_result = res;
        tick();
        u_if.enc_ack    = 1'b0;
        u_if.enc_result = 5'd0;
    endtask

    initial begin
        int r0;
        int bad;
        logic [7:0] codes [6];
        logic [4:0] idxs  [6];
        codes = '{8'h24, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42};
        idxs  = '{5'd4, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};

        reset_L         = 1'b0;
        scan_valid      = 1'b0;
        scan_code       = 8'h00;
        u_if.enc_ack    = 1'b0;
        u_if.enc_result = 5'd0;
        tick();
        tick();

        // Reset state
        check("rst_req",     u_if.enc_req, 1'b0);
        check("rst_letter",  u_if.enc_letter, 5'd0);
        check("rst_busy",    busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_tmo",     timeout_err, 1'b0);
        check("rst_count",   disp_count, 4'd0);
        check("rst_disp",    disp_letters, 20'hFFFFF);
        reset_L = 1'b1;
        tick();

        // Single press of A, ack one cycle after req
        r0 = req_rises;
        send(8'h1C);
        check("a_req",    u_if.enc_req, 1'b1);
        check("a_letter", u_if.enc_letter, 5'd0);
        check("a_busy",   busy, 1'b1);
        ack(5'd7);
        check("a_req_drop", u_if.enc_req, 1'b0);
        check("a_busy_drop", busy, 1'b0);
        check("a_count",  disp_count, 4'd1);
        check("a_disp",   disp_letters, pack(5'h1F, 5'h1F, 5'h1F, 5'd7));
        send(8'hF0);
        send(8'h1C);
        tick();
        check("a_one_req", req_rises - r0, 1);

        // Typematic repeats suppressed until break
        r0 = req_rises;
        send(8'h1C);
        ack(5'd3);
        send(8'h1C);
        check("typ_no_req1", u_if.enc_req, 1'b0);
        send(8'h1C);
        check("typ_no_req2", u_if.enc_req, 1'b0);
        tick();
        check("typ_one_req", req_rises - r0, 1);
        send(8'hF0);
        send(8'h1C);
        send(8'h1C);
        check("typ_req_after_brk", u_if.enc_req, 1'b1);
        ack(5'd4);
        check("typ_disp", disp_letters, pack(5'h1F, 5'd7, 5'd3, 5'd4));
        send(8'hF0);
        send(8'h1C);

        // Overrun: second key while busy is dropped
        send(8'h32);
        check("ovr_letter", u_if.enc_letter, 5'd1);
        send(8'h21);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_letter_kept", u_if.enc_letter, 5'd1);
        tick();
        check("ovr_pulse_end", overrun, 1'b0);
        ack(5'd9);
        check("ovr_count", disp_count, 4'd4);
        check("ovr_disp", disp_letters, pack(5'd7, 5'd3, 5'd4, 5'd9));
        send(8'hF0);
        send(8'h21);
        send(8'hF0);
        send(8'h32);
        check("ovr_no_stray_req", u_if.enc_req, 1'b0);

        // Timeout with no ack
        send(8'h2B);
        check("tmo_letter", u_if.enc_letter, 5'd5);
        bad = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            if (u_if.enc_req !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        check("tmo_hold", bad, 0);
        tick();
        check("tmo_pulse", timeout_err, 1'b1);
        check("tmo_req_drop", u_if.enc_req, 1'b0);
        check("tmo_busy_drop", busy, 1'b0);
        check("tmo_count", disp_count, 4'd4);
        check("tmo_disp", disp_letters, pack(5'd7, 5'd3, 5'd4, 5'd9));
        tick();
        check("tmo_pulse_end", timeout_err, 1'b0);
        send(8'hF0);
        send(8'h2B);

        // Ack on the final cycle of the window wins
        send(8'h2B);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("last_req_still", u_if.enc_req, 1'b1);
        ack(5'd10);
        check("last_no_tmo", timeout_err, 1'b0);
        check("last_req_drop", u_if.enc_req, 1'b0);
        check("last_disp", disp_letters, pack(5'd3, 5'd4, 5'd9, 5'd10));
        send(8'hF0);
        send(8'h2B);

        // Six presses, results 1..6; history saturates
        for (int i = 0; i < 6; i++) begin
            send(codes[i]);
            check("six_letter", u_if.enc_letter, idxs[i]);
            ack(5'(i + 1));
            send(8'hF0);
            send(codes[i]);
        end
        check("six_count", disp_count, 4'd4);
        check("six_disp", disp_letters, pack(5'd3, 5'd4, 5'd5, 5'd6));

        // Extended codes never issue requests
        r0 = req_rises;
        send(8'hE0);
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        tick();
        check("ext_no_req", req_rises - r0, 0);
        send(8'h1A);
        check("ext_then_z", u_if.enc_letter, 5'd25);
        ack(5'd11);
        check("z_disp", disp_letters, pack(5'd4, 5'd5, 5'd6, 5'd11));

        // Ack while idle is ignored
        ack(5'd2);
        check("idle_ack_disp", disp_letters, pack(5'd4, 5'd5, 5'd6, 5'd11));
        send(8'hF0);
        send(8'h1A);

        // Asynchronous reset mid-request
        send(8'h1C);
        check("mid_req", u_if.enc_req, 1'b1);
        reset_L = 1'b0;
        #2;
        check("mid_rst_req",   u_if.enc_req, 1'b0);
        check("mid_rst_busy",  busy, 1'b0);
        check("mid_rst_count", disp_count, 4'd0);
        check("mid_rst_disp",  disp_letters, 20'hFFFFF);
        #2;
        reset_L = 1'b1;
        tick();

        // Held key cleared by reset: 1C presses again
        send(8'h1C);
        check("post_rst_press", u_if.enc_req, 1'b1);
        ack(5'd12);
        send(8'hF0);
        send(8'h1C);
        send(8'h32);
        ack(5'd13);
        check("two_entries", disp_letters, pack(5'h1F, 5'h1F, 5'd12, 5'd13));

`ifdef BACKSPACE_EN
        send(8'h66);
        check("bs_count", disp_count, 4'd1);
        check("bs_disp", disp_letters, pack(5'h1F, 5'h1F, 5'h1F, 5'd12));
        send(8'hF0);
        send(8'h66);
        send(8'h66);
        check("bs_to_zero", disp_count, 4'd0);
        send(8'h66);
        check("bs_floor", disp_count, 4'd0);
        check("bs_floor_disp", disp_letters, 20'hFFFFF);
        send(8'hF0);
        send(8'h32);
        send(8'h32);
        send(8'h66);
        check("bs_busy_ovr", overrun, 1'b1);
        ack(5'd1);
        check("bs_busy_count", disp_count, 4'd1);
`else
        send(8'h66);
        check("bs_ignored_count", disp_count, 4'd2);
        check("bs_ignored_ovr", overrun, 1'b0);
        check("bs_ignored_disp", disp_letters, pack(5'h1F, 5'h1F, 5'd12, 5'd13));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
